alsu_result_capture: RTL and testbench

Registered output stage directly downstream of the negative-sign flag handler in the 4-bit ALSU. Each cycle it can accept one ALSU result together with its carry flag and negative sign flag, and it computes a zero flag. Results are held in a 2-entry FIFO/skid buffer with a valid/ready handshake to the consumer. The block also keeps sticky status bits and a saturating operation counter for status readout.

---
 rtl/alsu_result_capture.sv | 143 ++++++++++++++
 tb/tb_alsu_result_capture.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_result_capture.sv
// ---------------------------------------------------------------------------
// alsu_result_capture
//
// Registered output stage that sits after the ALSU negative-sign flag handler.
// Accepts one result per cycle (result, carry, negative flag, opcode), derives
// a zero flag and holds up to two results in a small FIFO / skid buffer.
// Sticky status bits and a saturating counter summarise the accepted
// operations.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  upstream handshake (in_ready depends only on state)
//   in_sel             opcode that produced the result
//   in_result          ALSU result (DATA_W bits)
//   in_carry, in_neg   carry/borrow flag and negative sign flag
//   out_valid/out_ready downstream handshake for the head entry
//   out_sel, out_result, out_carry, out_neg, out_zero  head entry fields
//   sticky_clr         synchronous clear of sticky bits and op_count
//   sticky_neg         a negative result was accepted since the last clear
//   sticky_carry       a carry was accepted since the last clear
//   op_count           accepted operations, saturating at all-ones
// ---------------------------------------------------------------------------
module alsu_result_capture #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_sel,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_carry,
    input  logic              in_neg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_sel,
    output logic [DATA_W-1:0] out_result,
    output logic              out_carry,
    output logic              out_neg,
    output logic              out_zero,
    input  logic              sticky_clr,
    output logic              sticky_neg,
    output logic              sticky_carry,
    output logic [CNT_W-1:0]  op_count
);

    typedef struct packed {
        logic [3:0]        sel;
        logic [DATA_W-1:0] result;
        logic              carry;
        logic              neg;
        logic              zero;
    } entry_t;

    entry_t     mem [2];
    logic [1:0] count;
    logic       wr_ptr;
    logic       rd_ptr;

    logic   push;
    logic   pop;
    logic   neg_masked;
    entry_t new_entry;
    entry_t head;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // The sign flag is only meaningful for the two opcodes that can produce a
    // signed result; anything else is forced to zero so a stray flag from the
    // sign handler never reaches the consumer or the sticky bit.
    assign neg_masked = in_neg & ((in_sel == 4'b0000) || (in_sel == 4'b1100));

    always_comb begin
        new_entry        = '0;
        new_entry.sel    = in_sel;
        new_entry.result = in_result;
        new_entry.carry  = in_carry;
        new_entry.neg    = neg_masked;
        new_entry.zero   = (in_result == '0);
    end

    // Outputs come straight from the head storage register, so they are
    // stable while the head waits for out_ready.
    assign head       = mem[rd_ptr];
    assign out_sel    = head.sel;
    assign out_result = head.result;
    assign out_carry  = head.carry;
    assign out_neg    = head.neg;
    assign out_zero   = head.zero;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            // NOTE: the storage entries are reset on purpose: outputs read the
            // head entry directly and must show all zeros after reset.
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Clear has priority but does not swallow a simultaneous push: the push
    // is applied on top of the cleared state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_neg   <= 1'b0;
            sticky_carry <= 1'b0;
            op_count     <= '0;
        end else if (sticky_clr) begin
            sticky_neg   <= push & neg_masked;
            sticky_carry <= push & in_carry;
            op_count     <= push ? CNT_W'(1) : '0;
        end else if (push) begin
            sticky_neg   <= sticky_neg | neg_masked;
            sticky_carry <= sticky_carry | in_carry;
            if (op_count != {CNT_W{1'b1}}) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alsu_result_capture.sv
// ---------------------------------------------------------------------------
// tb_alsu_result_capture
//
// Directed testbench for alsu_result_capture. Inputs are driven 1 ns after
// the rising edge and outputs are compared at the same point, i.e. showing
// the state produced by the edge just taken.
// ---------------------------------------------------------------------------
module tb_alsu_result_capture;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_sel;
    logic [DATA_W-1:0] in_result;
    logic              in_carry;
    logic              in_neg;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_sel;
    logic [DATA_W-1:0] out_result;
    logic              out_carry;
    logic              out_neg;
    logic              out_zero;
    logic              sticky_clr;
    logic              sticky_neg;
    logic              sticky_carry;
    logic [CNT_W-1:0]  op_count;

    int n_checks = 0;
    int n_fail   = 0;

    alsu_result_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sel       (in_sel),
        .in_result    (in_result),
        .in_carry     (in_carry),
        .in_neg       (in_neg),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sel      (out_sel),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_neg      (out_neg),
        .out_zero     (out_zero),
        .sticky_clr   (sticky_clr),
        .sticky_neg   (sticky_neg),
        .sticky_carry (sticky_carry),
        .op_count     (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] sel, input logic [3:0] res,
                         input logic carry, input logic neg);
        in_valid  = 1'b1;
        in_sel    = sel;
        in_result = res;
        in_carry  = carry;
        in_neg    = neg;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_sel     = 4'd0;
        in_result  = 4'd0;
        in_carry   = 1'b0;
        in_neg     = 1'b0;
        out_ready  = 1'b0;
        sticky_clr = 1'b0;

        // Reset state (in_ready reads 1 while reset is held)
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_op_count", op_count, 0);
        check("rst_sticky_neg", sticky_neg, 0);
        rst = 1'b0;
        step();

        // Single push, one-cycle latency
        out_ready = 1'b1;
        drive(4'b0000, 4'b1011, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        check("p1_out_valid", out_valid, 1);
        check("p1_out_result", out_result, 4'b1011);
        check("p1_out_neg", out_neg, 1);
        check("p1_out_zero", out_zero, 0);
        check("p1_sticky_neg", sticky_neg, 1);
        check("p1_op_count", op_count, 1);
        step();
        check("p1_drained", out_valid, 0);

        // Backpressure: 5, 0, 9 with out_ready low
        out_ready = 1'b0;
        drive(4'b0010, 4'd5, 1'b0, 1'b0);
        step();
        check("bp_ready_after1", in_ready, 1);
        drive(4'b0010, 4'd0, 1'b1, 1'b0);
        step();
        check("bp_ready_after2", in_ready, 0);
        drive(4'b0010, 4'd9, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("bp_head_hold", out_result, 5);
            check("bp_full", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        check("bp_head5", out_result, 5);
        step();
        check("bp_head0", out_result, 0);
        check("bp_zero", out_zero, 1);
        check("bp_carry", out_carry, 1);
        step();
        in_valid = 1'b0;
        check("bp_head9", out_result, 9);
        check("bp_valid9", out_valid, 1);
        step();
        check("bp_empty", out_valid, 0);
        check("bp_op_count", op_count, 4);
        check("bp_sticky_carry", sticky_carry, 1);

        // Sticky clear without push
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("clr_op_count", op_count, 0);
        check("clr_sticky_neg", sticky_neg, 0);
        check("clr_sticky_carry", sticky_carry, 0);

        // Negative flag masking for non-signed opcode
        out_ready = 1'b0;
        drive(4'b0101, 4'd3, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        check("mask_out_neg", out_neg, 0);
        check("mask_out_result", out_result, 3);
        check("mask_out_sel", out_sel, 4'b0101);
        check("mask_sticky_neg", sticky_neg, 0);
        out_ready = 1'b1;
        step();
        check("mask_drained", out_valid, 0);

        // Streaming with simultaneous push/pop
        for (int i = 0; i < 10; i++) begin
            drive(4'b0011, 4'(i), 1'b0, 1'b0);
            step();
            check("stream_valid", out_valid, 1);
            check("stream_data", out_result, i);
            check("stream_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", out_valid, 0);
        check("stream_op_count", op_count, 11);

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            drive(4'b0010, 4'(i), 1'b0, 1'b0);
            step();
        end
        in_valid = 1'b0;
        step();
        check("sat_op_count", op_count, 255);
        check("sat_drained", out_valid, 0);

        // Clear together with a push
        sticky_clr = 1'b1;
        drive(4'b1100, 4'd6, 1'b1, 1'b1);
        step();
        sticky_clr = 1'b0;
        in_valid   = 1'b0;
        check("clrpush_op_count", op_count, 1);
        check("clrpush_sticky_neg", sticky_neg, 1);
        check("clrpush_sticky_carry", sticky_carry, 1);
        check("clrpush_out_neg", out_neg, 1);
        step();

        // Asynchronous reset with two entries buffered
        out_ready = 1'b0;
        drive(4'b0001, 4'd7, 1'b1, 1'b0);
        step();
        drive(4'b0001, 4'd8, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        check("pre_rst_full", in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_result", out_result, 0);
        check("arst_out_sel", out_sel, 0);
        check("arst_out_carry", out_carry, 0);
        check("arst_out_zero", out_zero, 0);
        check("arst_op_count", op_count, 0);
        #2;
        rst = 1'b0;
        step();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        out_ready = 1'b1;
        drive(4'b0001, 4'd4, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        check("post_rst_valid", out_valid, 1);
        check("post_rst_result", out_result, 4);
        check("post_rst_sel", out_sel, 4'b0001);
        check("post_rst_op_count", op_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
